alloc_dispatcher: RTL and testbench

Front-end stage of the MMU allocation path. It accepts raw byte-size allocation requests from the host over a valid/ready handshake, classifies each size into the 512/1K/2K/4K size-type code, and buffers requests in a small in-order FIFO. It issues requests one at a time to the find-table stage. When the find-table reports `fdt_blocked`, it retains the head request and retries it until the find-table accepts it.

---
 rtl/alloc_dispatcher.sv | 169 ++++++++++++++++
 tb/tb_alloc_dispatcher.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alloc_dispatcher.sv
// Allocation front-end: classifies host byte sizes into size-type codes, buffers them in order
// and issues one request at a time to the find-table, re-issuing a blocked head after a backoff.
module alloc_dispatcher #(
  parameter int ID_WIDTH   = 8,
  parameter int SIZE_WIDTH = 13,
  parameter int FIFO_DEPTH = 4,
  parameter int RETRY_GAP  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ID_WIDTH-1:0]   req_id,
  input  logic [SIZE_WIDTH-1:0] req_size,
  output logic                  err_valid,
  output logic [ID_WIDTH-1:0]   err_id,
  output logic                  alloc_valid_out,
  output logic [ID_WIDTH-1:0]   alloc_id_out,
  output logic [1:0]            alloc_size_out,
  input  logic                  fdt_blocked,
  output logic [15:0]           retry_count,
  output logic                  busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BO_W  = $clog2(RETRY_GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_BACKOFF} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BO_W-1:0]     bo_cnt_q, bo_cnt_d;
  logic [15:0]         retry_q, retry_d;
  logic                alloc_valid_q, alloc_valid_d;
  logic [ID_WIDTH-1:0] alloc_id_q, alloc_id_d;
  logic [1:0]          alloc_size_q, alloc_size_d;
  logic                err_valid_q, err_valid_d;
  logic [ID_WIDTH-1:0] err_id_q, err_id_d;

  logic [ID_WIDTH-1:0] fifo_id_mem   [FIFO_DEPTH];
  logic [1:0]          fifo_size_mem [FIFO_DEPTH];

  logic             size_legal;
  logic [1:0]       size_code;
  logic             accept;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] rd_ptr_next;

  always_comb begin
    size_legal = (req_size != '0) && (req_size <= SIZE_WIDTH'(4096));
    if (req_size <= SIZE_WIDTH'(512))       size_code = 2'd0;
    else if (req_size <= SIZE_WIDTH'(1024)) size_code = 2'd1;
    else if (req_size <= SIZE_WIDTH'(2048)) size_code = 2'd2;
    else                                    size_code = 2'd3;
  end

  assign req_ready   = (count_q < CNT_W'(FIFO_DEPTH));
  assign accept      = req_valid && req_ready;
  assign push        = accept && size_legal;
  assign pop         = (state_q == S_WAIT) && !fdt_blocked;
  assign rd_ptr_next = rd_ptr_q + PTR_W'(1);
  assign busy        = (count_q != '0) || (state_q != S_IDLE);

  assign alloc_valid_out = alloc_valid_q;
  assign alloc_id_out    = alloc_id_q;
  assign alloc_size_out  = alloc_size_q;
  assign err_valid       = err_valid_q;
  assign err_id          = err_id_q;
  assign retry_count     = retry_q;

  always_comb begin
    // NOTE: every _d takes a default before the case so no path through this block infers a latch.
    state_d       = state_q;
    wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_next : rd_ptr_q;
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    bo_cnt_d      = bo_cnt_q;
    retry_d       = retry_q;
    alloc_valid_d = 1'b0;
    alloc_id_d    = alloc_id_q;
    alloc_size_d  = alloc_size_q;
    err_valid_d   = accept && !size_legal;
    err_id_d      = (accept && !size_legal) ? req_id : err_id_q;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d       = S_ISSUE;
          alloc_valid_d = 1'b1;
          alloc_id_d    = fifo_id_mem[rd_ptr_q];
          alloc_size_d  = fifo_size_mem[rd_ptr_q];
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (fdt_blocked) begin
          state_d  = S_BACKOFF;
          bo_cnt_d = BO_W'(RETRY_GAP - 1);
          if (retry_q != 16'hFFFF) retry_d = retry_q + 16'd1;
        end else if (count_d != '0) begin
          state_d       = S_ISSUE;
          alloc_valid_d = 1'b1;
          // With one entry left, the new head is the request being written on this same edge.
          if (count_q == CNT_W'(1)) begin
            alloc_id_d   = req_id;
            alloc_size_d = size_code;
          end else begin
            alloc_id_d   = fifo_id_mem[rd_ptr_next];
            alloc_size_d = fifo_size_mem[rd_ptr_next];
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BACKOFF: begin
        if (bo_cnt_q == '0) begin
          state_d       = S_ISSUE;
          alloc_valid_d = 1'b1;
          alloc_id_d    = fifo_id_mem[rd_ptr_q];
          alloc_size_d  = fifo_size_mem[rd_ptr_q];
        end else begin
          bo_cnt_d = bo_cnt_q - BO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      bo_cnt_q      <= '0;
      retry_q       <= '0;
      alloc_valid_q <= 1'b0;
      alloc_id_q    <= '0;
      alloc_size_q  <= '0;
      err_valid_q   <= 1'b0;
      err_id_q      <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      bo_cnt_q      <= bo_cnt_d;
      retry_q       <= retry_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_id_q    <= alloc_id_d;
      alloc_size_q  <= alloc_size_d;
      err_valid_q   <= err_valid_d;
      err_id_q      <= err_id_d;
    end
  end

  // NOTE: buffer storage is not reset; count and pointers guard every read, so stale data is never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id_mem[wr_ptr_q]   <= req_id;
      fifo_size_mem[wr_ptr_q] <= size_code;
    end
  end

endmodule

// File: tb/tb_alloc_dispatcher.sv
// Randomized and directed bench for alloc_dispatcher, checked every cycle against a
// schedule-based queue model of the dispatcher's issue/retry rules.
module tb_alloc_dispatcher;
  localparam int ID_WIDTH   = 8;
  localparam int SIZE_WIDTH = 13;
  localparam int FIFO_DEPTH = 4;
  localparam int RETRY_GAP  = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  req_valid;
  logic                  req_ready;
  logic [ID_WIDTH-1:0]   req_id;
  logic [SIZE_WIDTH-1:0] req_size;
  logic                  err_valid;
  logic [ID_WIDTH-1:0]   err_id;
  logic                  alloc_valid_out;
  logic [ID_WIDTH-1:0]   alloc_id_out;
  logic [1:0]            alloc_size_out;
  logic                  fdt_blocked;
  logic [15:0]           retry_count;
  logic                  busy;

  always #5 clk = ~clk;

  alloc_dispatcher #(
    .ID_WIDTH(ID_WIDTH), .SIZE_WIDTH(SIZE_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH), .RETRY_GAP(RETRY_GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_size(req_size),
    .err_valid(err_valid), .err_id(err_id),
    .alloc_valid_out(alloc_valid_out), .alloc_id_out(alloc_id_out), .alloc_size_out(alloc_size_out),
    .fdt_blocked(fdt_blocked), .retry_count(retry_count), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: in-order queue plus the cycle numbers of the next issue and next WAIT sample.
  typedef struct { logic [7:0] id; logic [1:0] code; } ent_t;
  ent_t        mq[$];
  int          m_t, m_next_issue, m_wait_at;
  bit          m_inflight;
  logic [15:0] m_retry;
  bit          m_err_v;
  logic [7:0]  m_err_id;
  bit          m_alloc_v;
  logic [7:0]  m_alloc_id;
  logic [1:0]  m_alloc_size;

  bit hold_block, rand_block, last_acc;
  int auto_block;
  int log_id[$], log_size[$], log_t[$], err_log[$];

  function automatic logic [1:0] size_class(int s);
    if (s <= 512)       return 2'd0;
    else if (s <= 1024) return 2'd1;
    else if (s <= 2048) return 2'd2;
    else                return 2'd3;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_t = 0; m_next_issue = -1; m_wait_at = -1; m_inflight = 0;
    m_retry = '0; m_err_v = 0; m_err_id = '0;
    m_alloc_v = 0; m_alloc_id = '0; m_alloc_size = '0;
  endfunction

  function automatic void clear_logs();
    log_id.delete(); log_size.delete(); log_t.delete(); err_log.delete();
  endfunction

  function automatic void model_edge(bit v, int id, int size, bit blk);
    bit   acc, legal, pop;
    int   pre;
    ent_t e;
    pre   = mq.size();
    acc   = v && (pre < FIFO_DEPTH);
    legal = (size >= 1) && (size <= 4096);
    m_err_v = acc && !legal;
    if (m_err_v) m_err_id = 8'(id);
    if (m_t == m_next_issue) m_wait_at = m_t + 1;
    pop = 0;
    if (m_t == m_wait_at) begin
      if (blk) begin
        if (m_retry != 16'hFFFF) m_retry = m_retry + 16'd1;
        m_next_issue = m_t + RETRY_GAP + 1;
      end else begin
        pop = 1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (acc && legal) begin
      e.id = 8'(id); e.code = size_class(size);
      mq.push_back(e);
    end
    if (pop) begin
      if (mq.size() > 0) m_next_issue = m_t + 1;
      else m_inflight = 0;
    end else if (!m_inflight && pre > 0) begin
      m_inflight   = 1;
      m_next_issue = m_t + 1;
    end
    m_t++;
    m_alloc_v = (m_t == m_next_issue);
    if (m_alloc_v) begin
      m_alloc_id   = mq[0].id;
      m_alloc_size = mq[0].code;
    end
  endfunction

  task automatic tick(input bit v, input int id, input int size);
    bit blk;
    bit dut_ready;
    @(negedge clk);
    dut_ready = req_ready;
    check("alloc_valid", alloc_valid_out, m_alloc_v);
    check("alloc_id", alloc_id_out, m_alloc_id);
    check("alloc_size", alloc_size_out, m_alloc_size);
    check("err_valid", err_valid, m_err_v);
    if (m_err_v) check("err_id", err_id, m_err_id);
    check("req_ready", req_ready, mq.size() < FIFO_DEPTH);
    check("busy", busy, (mq.size() > 0) || m_inflight);
    check("retry_count", retry_count, m_retry);
    if (alloc_valid_out) begin
      log_id.push_back(int'(alloc_id_out));
      log_size.push_back(int'(alloc_size_out));
      log_t.push_back(m_t);
    end
    if (err_valid) err_log.push_back(int'(err_id));
    blk = hold_block;
    if (m_t == m_wait_at && auto_block > 0) begin
      blk = 1;
      auto_block--;
    end else if (rand_block) begin
      blk = ($urandom_range(0, 99) < 30);
    end
    req_valid   = v;
    req_id      = ID_WIDTH'(id);
    req_size    = SIZE_WIDTH'(size);
    fdt_blocked = blk;
    last_acc    = v && dut_ready;
    model_edge(v, id, size, blk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0);
  endtask

  task automatic send(input int id, input int size);
    for (int k = 0; k < 200; k++) begin
      tick(1, id, size);
      if (last_acc) break;
    end
    check("send_accepted", last_acc, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0; req_id = '0; req_size = '0; fdt_blocked = 1'b0;
    #1;
    check("rst_alloc_valid", alloc_valid_out, 0);
    check("rst_alloc_id", alloc_id_out, 0);
    check("rst_alloc_size", alloc_size_out, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_id", err_id, 0);
    check("rst_retry_count", retry_count, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    hold_block = 0; rand_block = 0; auto_block = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sweep_sz[8];
    int sweep_code[8];
    int bnd[8];
    int accept_t;
    int dedup[$];
    bit in_bo;
    int sz;

    sweep_sz   = '{1, 512, 513, 1024, 1025, 2048, 2049, 4096};
    sweep_code = '{0, 0, 1, 1, 2, 2, 3, 3};
    bnd        = sweep_sz;
    rst_n = 1'b0;
    req_valid = 1'b0; req_id = '0; req_size = '0; fdt_blocked = 1'b0;

    // Idle accept: single request, latency and drain.
    do_reset();
    clear_logs();
    idle(2);
    send(5, 700);
    accept_t = m_t - 1;
    idle(4);
    check("idle_issue_count", log_id.size(), 1);
    if (log_id.size() > 0) begin
      check("idle_issue_cycle", log_t[0], accept_t + 2);
      check("idle_issue_id", log_id[0], 5);
      check("idle_issue_size", log_size[0], 1);
    end
    check("idle_busy_clear", busy, 0);

    // Classification sweep across every size-code boundary.
    do_reset();
    clear_logs();
    for (int i = 0; i < 8; i++) send(20 + i, sweep_sz[i]);
    idle(40);
    check("sweep_count", log_id.size(), 8);
    for (int i = 0; i < 8 && i < log_id.size(); i++) begin
      check($sformatf("sweep_id%0d", i), log_id[i], 20 + i);
      check($sformatf("sweep_code%0d", i), log_size[i], sweep_code[i]);
      if (i > 0) check($sformatf("sweep_gap%0d", i), (log_t[i] - log_t[i-1]) >= 2, 1);
    end

    // Illegal sizes are rejected with an error pulse and never issued.
    do_reset();
    clear_logs();
    send(9, 0);
    send(10, 4097);
    idle(5);
    check("illegal_err_count", err_log.size(), 2);
    if (err_log.size() == 2) begin
      check("illegal_err_id0", err_log[0], 9);
      check("illegal_err_id1", err_log[1], 10);
    end
    check("illegal_no_issue", log_id.size(), 0);
    check("illegal_busy", busy, 0);

    // Two blocked WAIT samples: three issues spaced RETRY_GAP+2 apart.
    do_reset();
    clear_logs();
    auto_block = 2;
    send(3, 1000);
    idle(40);
    check("retry_issue_count", log_id.size(), 3);
    if (log_id.size() == 3) begin
      for (int i = 0; i < 3; i++) check($sformatf("retry_id%0d", i), log_id[i], 3);
      check("retry_gap1", log_t[1] - log_t[0], RETRY_GAP + 2);
      check("retry_gap2", log_t[2] - log_t[1], RETRY_GAP + 2);
    end
    check("retry_count_final", retry_count, 2);
    check("retry_busy", busy, 0);

    // Full FIFO: stall a fifth request, then drain in order.
    do_reset();
    clear_logs();
    hold_block = 1;
    for (int i = 1; i <= 4; i++) send(i, 100);
    for (int i = 0; i < 5; i++) begin
      tick(1, 5, 100);
      check("full_stall", last_acc, 0);
    end
    check("full_ready_low", req_ready, 0);
    hold_block = 0;
    send(5, 100);
    idle(40);
    foreach (log_id[i]) if (dedup.size() == 0 || dedup[$] != log_id[i]) dedup.push_back(log_id[i]);
    check("full_order_len", dedup.size(), 5);
    for (int i = 0; i < 5 && i < dedup.size(); i++) check($sformatf("full_order%0d", i), dedup[i], i + 1);

    // Reset in BACKOFF with three entries buffered drops everything.
    do_reset();
    clear_logs();
    hold_block = 1;
    for (int i = 1; i <= 3; i++) send(40 + i, 2000);
    in_bo = 0;
    for (int k = 0; k < 100 && !in_bo; k++) begin
      tick(0, 0, 0);
      in_bo = m_inflight && (m_t > m_wait_at) && (m_t < m_next_issue);
    end
    check("reached_backoff", in_bo, 1);
    do_reset();
    clear_logs();
    idle(30);
    check("post_reset_no_issue", log_id.size(), 0);
    check("post_reset_no_err", err_log.size(), 0);

    // Randomized traffic with random blocking.
    do_reset();
    rand_block = 1;
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 9))
        0:       sz = 0;
        1:       sz = $urandom_range(4097, 8191);
        2:       sz = bnd[$urandom_range(0, 7)];
        default: sz = $urandom_range(1, 4096);
      endcase
      tick($urandom_range(0, 1) == 1, $urandom_range(0, 255), sz);
    end
    rand_block = 0;
    idle(60);
    check("random_drain_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
